// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: owns the architectural Z/S flags, evaluates
// conditional branches with same-edge flag bypass, and drives PC redirect/flush.
module branch_resolve #(
    parameter int PC_W         = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flag_we,
    input  logic            alu_zero,
    input  logic            alu_sign,
    input  logic            br_valid,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_target,
    output logic            br_ready,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush,
    output logic            flag_z,
    output logic            flag_s,
    output logic [7:0]      taken_cnt
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] flush_cnt;
    logic             eff_z;
    logic             eff_s;
    logic             cond_met;
    logic             take;

    // A flag write on this edge must be seen by a branch on the same edge.
    always_comb begin
        eff_z = flag_we ? alu_zero : flag_z;
        eff_s = flag_we ? alu_sign : flag_s;
    end

    always_comb begin
        cond_met = 1'b0;
        case (br_cond)
            3'b000:  cond_met = 1'b1;
            3'b001:  cond_met = eff_z;
            3'b010:  cond_met = !eff_z;
            3'b011:  cond_met = eff_s;
            3'b100:  cond_met = !eff_s;
            3'b101:  cond_met = eff_z | eff_s;
            3'b110:  cond_met = !eff_z & !eff_s;
            default: cond_met = 1'b0;
        endcase
    end

    assign br_ready = (state == IDLE);
    assign flush    = (state == FLUSH);
    assign take     = br_valid & br_ready & cond_met;

    // Everything arriving during FLUSH is wrong-path, so IDLE alone updates flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            flag_z      <= 1'b0;
            flag_s      <= 1'b0;
            taken_cnt   <= 8'd0;
        end else begin
            redirect <= 1'b0;
            case (state)
                IDLE: begin
                    if (flag_we) begin
                        flag_z <= alu_zero;
                        flag_s <= alu_sign;
                    end
                    if (take) begin
                        redirect_pc <= br_target;
                        redirect    <= 1'b1;
                        flush_cnt   <= CNT_W'(FLUSH_CYCLES);
                        state       <= FLUSH;
                        if (taken_cnt != 8'hFF)
                            taken_cnt <= taken_cnt + 8'd1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == CNT_W'(1))
                        state <= IDLE;
                    flush_cnt <= flush_cnt - CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
